// File: rtl/uart_core.sv
// uart_core: full-duplex UART with independent tx/rx tick dividers and a mid-bit oversampling receiver.
// Defining UART_CORE_PARITY_EN adds an optional parity bit selected by the PARITY parameter.
module uart_core #(
  parameter int CLOCK_DIVIDE = 13,
  parameter int OVERSAMPLE   = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 tx_busy,
  output logic                 rx_busy
);
  localparam int DIV_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int CNT_W = 4;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLOCK_DIVIDE - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

`ifdef UART_CORE_PARITY_EN
  localparam bit PAR_ON = (PARITY == 1) || (PARITY == 2);
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ~(^d) : ^d;
  endfunction
`else
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
`endif

  tx_state_t            tx_state, tx_next;
  logic [DIV_W-1:0]     tx_div;
  logic [OS_W-1:0]      tx_os;
  logic [CNT_W-1:0]     tx_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_tick, tx_bit_end, tx_d;
`ifdef UART_CORE_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_tick    = (tx_div == '0);
  assign tx_bit_end = tx_tick && (tx_os == OS_LAST);
  assign tx_ready   = (tx_state == TX_IDLE);
  assign tx_busy    = (tx_state != TX_IDLE);

  // tx is registered from the next state so the serial line never glitches
  always_comb begin
    tx_next = tx_state;
    tx_d    = 1'b1;
    case (tx_state)
      TX_IDLE:  if (tx_valid) tx_next = TX_START;
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:
        if (tx_bit_end && (tx_cnt == DATA_LAST)) begin
`ifdef UART_CORE_PARITY_EN
          tx_next = PAR_ON ? TX_PARITY : TX_STOP;
`else
          tx_next = TX_STOP;
`endif
        end
`ifdef UART_CORE_PARITY_EN
      TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
`endif
      TX_STOP:  if (tx_bit_end && (tx_cnt == STOP_LAST)) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
    case (tx_next)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = ((tx_state == TX_DATA) && tx_bit_end) ? tx_shift[1] : tx_shift[0];
`ifdef UART_CORE_PARITY_EN
      TX_PARITY: tx_d = tx_par;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_div   <= DIV_LAST;
      tx_os    <= '0;
      tx_cnt   <= '0;
      tx_shift <= '0;
`ifdef UART_CORE_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_next;
      tx       <= tx_d;
      if (tx_state == TX_IDLE) begin
        tx_div <= DIV_LAST;
        tx_os  <= '0;
        tx_cnt <= '0;
        if (tx_valid) begin
          tx_shift <= tx_data;
`ifdef UART_CORE_PARITY_EN
          tx_par   <= parity_of(tx_data);
`endif
        end
      end else begin
        tx_div <= tx_tick ? DIV_LAST : tx_div - DIV_W'(1);
        if (tx_tick) tx_os <= tx_bit_end ? '0 : tx_os + OS_W'(1);
        if (tx_bit_end) begin
          tx_cnt <= (tx_next != tx_state) ? '0 : tx_cnt + CNT_W'(1);
          if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
        end
      end
    end
  end

  rx_state_t            rx_state, rx_next;
  logic                 rx_meta, rx_sync;
  logic [DIV_W-1:0]     rx_div;
  logic [OS_W-1:0]      rx_os;
  logic [CNT_W-1:0]     rx_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_tick, rx_sample;
`ifdef UART_CORE_PARITY_EN
  logic                 rx_par_bit;
`else
  assign rx_parity_err = 1'b0;
`endif

  // the start bit is sampled half a bit in, every later bit one full bit after that
  assign rx_tick   = (rx_div == '0);
  assign rx_sample = rx_tick && (rx_os == ((rx_state == RX_START) ? OS_HALF : OS_LAST));
  assign rx_busy   = (rx_state != RX_IDLE);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_next = RX_START;
      RX_START: if (rx_sample) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (rx_sample && (rx_cnt == DATA_LAST)) begin
`ifdef UART_CORE_PARITY_EN
          rx_next = PAR_ON ? RX_PARITY : RX_STOP;
`else
          rx_next = RX_STOP;
`endif
        end
`ifdef UART_CORE_PARITY_EN
      RX_PARITY: if (rx_sample) rx_next = RX_STOP;
`endif
      RX_STOP:      if (rx_sample) rx_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_sync) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_div       <= DIV_LAST;
      rx_os        <= '0;
      rx_cnt       <= '0;
      rx_shift     <= '0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_frame_err <= 1'b0;
`ifdef UART_CORE_PARITY_EN
      rx_par_bit    <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_next;
      rx_valid <= 1'b0;
      if ((rx_state == RX_IDLE) || (rx_state == RX_WAIT_HIGH)) begin
        rx_div <= DIV_LAST;
        rx_os  <= '0;
        rx_cnt <= '0;
      end else begin
        rx_div <= rx_tick ? DIV_LAST : rx_div - DIV_W'(1);
        if (rx_tick) rx_os <= rx_sample ? '0 : rx_os + OS_W'(1);
        if (rx_sample) begin
          rx_cnt <= (rx_next != rx_state) ? '0 : rx_cnt + CNT_W'(1);
          if (rx_state == RX_DATA) rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
`ifdef UART_CORE_PARITY_EN
          if (rx_state == RX_PARITY) rx_par_bit <= rx_sync;
`endif
          if (rx_state == RX_STOP) begin
            rx_valid     <= 1'b1;
            rx_data      <= rx_shift;
            rx_frame_err <= !rx_sync;
`ifdef UART_CORE_PARITY_EN
            rx_parity_err <= PAR_ON && (rx_par_bit != parity_of(rx_shift));
`endif
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed bench for uart_core; expected received words go through a scoreboard queue
// that a monitor pops on every rx_valid, tx waveforms are checked bit by bit against a frame model.
`timescale 1ns/1ps
module tb_uart_core;
  localparam int CD = 4;
  localparam int OS = 16;
`ifdef UART_CORE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BIT_CLKS = CD * OS;
  localparam int NBITS    = 10 + ((PAR != 0) ? 1 : 0);

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;
  logic       tx, tx_valid, tx_ready, rx_valid, rx_frame_err, rx_parity_err, tx_busy, rx_busy;
  logic [7:0] tx_data, rx_data;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   rv_times[$];

  assign rx_line = loop_en ? tx : rx_drv;

  uart_core #(
    .CLOCK_DIVIDE(CD), .OVERSAMPLE(OS), .DATA_BITS(8), .STOP_BITS(1), .PARITY(PAR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx_line), .tx(tx),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .tx_busy(tx_busy), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic parBit(input logic [7:0] d);
    return (PAR == 2) ? ~(^d) : ^d;
  endfunction

  function automatic logic [NBITS-1:0] frameBits(input logic [7:0] d);
    logic [NBITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (PAR != 0) f[9] = parBit(d);
    return f;
  endfunction

  // scoreboard consumer: every rx_valid must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("[TB] FAIL unexpected_rx_valid: observed data 0x%0h, expected no rx_valid", rx_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rx_data", rx_data, e.data);
        checkOutput("rx_frame_err", rx_frame_err, e.ferr);
        checkOutput("rx_parity_err", rx_parity_err, e.perr);
        rv_times.push_back(cyc);
      end
    end
  end

  // one handshake; returns at the falling edge right after the accepting clock edge
  task automatic applyStimulus(input logic [7:0] d);
    int waited = 0;
    @(negedge clk);
    while (!tx_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("tx_ready_before_send", tx_ready, 1'b1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~d;
  endtask

  task automatic checkTxFrame(input logic [7:0] d);
    logic [NBITS-1:0] bits;
    bits = frameBits(d);
    checkOutput("tx_low_after_handshake", tx, 1'b0);
    repeat (BIT_CLKS / 2) @(negedge clk);
    for (int b = 0; b < NBITS; b++) begin
      checkOutput($sformatf("tx_bit%0d_of_%02h", b, d), tx, bits[b]);
      if (b == 0) begin
        repeat (BIT_CLKS / 2 - 1) @(negedge clk);
        checkOutput("tx_start_bit_tail", tx, 1'b0);
        @(negedge clk);
        checkOutput("tx_bit1_head", tx, bits[1]);
        repeat (BIT_CLKS / 2) @(negedge clk);
      end else if (b < NBITS - 1) begin
        repeat (BIT_CLKS) @(negedge clk);
      end
    end
    repeat (BIT_CLKS / 2 - 1) @(negedge clk);
    checkOutput("tx_ready_before_frame_end", tx_ready, 1'b0);
    @(negedge clk);
    checkOutput("tx_ready_at_frame_end", tx_ready, 1'b1);
  endtask

  task automatic driveRxFrame(input logic [7:0] d, input logic par, input logic stop);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (PAR != 0) begin
      rx_drv = par;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_drv = stop;
    repeat (BIT_CLKS) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  task automatic waitDrain(input string tag);
    int waited = 0;
    while (sb.size() != 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput(tag, sb.size(), 0);
  endtask

  initial begin
    int waited;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_tx_ready", tx_ready, 1'b1);
    checkOutput("reset_busy", {tx_busy, rx_busy}, 2'b00);
    checkOutput("reset_rx_valid", rx_valid, 1'b0);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_err", {rx_frame_err, rx_parity_err}, 2'b00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single frame on tx
    $display("[TB] tx frame 0xA5");
    applyStimulus(8'hA5);
    checkTxFrame(8'hA5);
    applyStimulus(8'h07);
    checkTxFrame(8'h07);

    // loopback, tx_valid held across two frames, tx_data changed mid-frame
    $display("[TB] loopback back-to-back");
    loop_en = 1'b1;
    rv_times.delete();
    sb.push_back('{8'h3C, 1'b0, 1'b0});
    sb.push_back('{8'hC3, 1'b0, 1'b0});
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(negedge clk);
    checkOutput("b2b_first_accepted", tx_busy, 1'b1);
    tx_data = 8'hC3;
    waited = 0;
    while (!tx_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("b2b_ready_again", tx_ready, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    waitDrain("b2b_sb_drained");
    checkOutput("b2b_rx_count", rv_times.size(), 2);
    if (rv_times.size() == 2)
      checkOutput("b2b_spacing", ((rv_times[1] - rv_times[0]) == NBITS * BIT_CLKS) ||
                                 ((rv_times[1] - rv_times[0]) == NBITS * BIT_CLKS + 1), 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    loop_en = 1'b0;

    // short low glitch on rx
    $display("[TB] rx glitch");
    rx_drv = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("glitch_rx_busy_high", rx_busy, 1'b1);
    repeat (10) @(negedge clk);
    rx_drv = 1'b1;
    repeat (80) @(negedge clk);
    checkOutput("glitch_rx_busy_low", rx_busy, 1'b0);
    checkOutput("glitch_no_frame_err", rx_frame_err, 1'b0);

    // line break
    $display("[TB] rx break");
    sb.push_back('{8'h00, 1'b1, 1'b0});
    rx_drv = 1'b0;
    repeat (1000) @(negedge clk);
    checkOutput("break_rx_busy_held", rx_busy, 1'b1);
    checkOutput("break_sb_drained", sb.size(), 0);
    rx_drv = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("break_rx_busy_released", rx_busy, 1'b0);

    // directly driven rx frames
    $display("[TB] rx direct frames");
    sb.push_back('{8'h5A, 1'b0, 1'b0});
    driveRxFrame(8'h5A, parBit(8'h5A), 1'b1);
`ifdef UART_CORE_PARITY_EN
    sb.push_back('{8'h07, 1'b0, 1'b1});
    driveRxFrame(8'h07, 1'b0, 1'b1);
`endif
    sb.push_back('{8'h81, 1'b1, 1'b0});
    driveRxFrame(8'h81, parBit(8'h81), 1'b0);
    waitDrain("direct_sb_drained");
    checkOutput("direct_rx_idle", rx_busy, 1'b0);
    checkOutput("direct_rx_data_held", rx_data, 8'h81);

    // asynchronous reset in the middle of a tx frame
    $display("[TB] reset mid-frame");
    applyStimulus(8'hA5);
    repeat (299) @(negedge clk);
    checkOutput("midframe_tx_low", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_tx", tx, 1'b1);
    checkOutput("async_reset_tx_ready", tx_ready, 1'b1);
    checkOutput("async_reset_tx_busy", tx_busy, 1'b0);
    checkOutput("async_reset_rx_data", rx_data, 8'h00);
    checkOutput("async_reset_frame_err", rx_frame_err, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_tx_idle", tx, 1'b1);
    applyStimulus(8'h3C);
    checkTxFrame(8'h3C);

    repeat (20) @(negedge clk);
    checkOutput("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
